uart_rx_controller: RTL and testbench

- Sequences UART frame reception using the baud divisor measured by the auto-baud block.
- Takes `brg`, the clocks-per-bit value latched from the auto-baud result register, and the serial line `UxRX`.
- Times mid-bit sampling, assembles 8 data bits LSB-first, checks the stop bit and raises `UxRXIF` per received byte.
- Sits between the auto-baud circuit and the UART receive buffer.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/uart_rx_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive controller.
//   - rx_state_t : receiver FSM state encoding
//   - DATA_BITS  : data bits per frame
//   - even_parity_err() : even-parity error of a data byte and its parity bit
// Optional feature macro used by the controller: UART_RX_PARITY_EN
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_CHK = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Even parity: the XOR of the data and the parity bit must be 0.
  function automatic logic even_parity_err(input logic [DATA_BITS-1:0] data,
                                           input logic                 par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Loadable down-counter that paces bit sampling. tc marks the cycle in which
// the count equals 1; the owner normally reloads on that cycle. A count of 0
// is parked and never produces tc.
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset (count -> 0)
//   load    in   load loadVal on the next edge (takes priority over counting)
//   loadVal in   CNT_W value to load
//   tc      out  terminal count (count == 1)
// -----------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // Counter register: load has priority, otherwise count down to 0 and park.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {CNT_W{1'b0}};
    end else if (load) begin
      count <= loadVal;
    end else if (count != {CNT_W{1'b0}}) begin
      count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign tc = (count == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/uart_rx_controller.sv
// -----------------------------------------------------------------------------
// uart_rx_controller
// Receives 8N1 UART frames using a clocks-per-bit value supplied by the
// auto-baud block. Samples each bit at its centre, assembles data LSB-first,
// checks the stop bit and pulses UxRXIF once per received byte.
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   UxRX    in   raw serial line, idle high (synchronised internally)
//   brg     in   CNT_W clocks per bit; values below 2 block frame start
//   rxEn    in   receiver enable; low aborts any frame in progress
//   rxData  out  last received byte
//   UxRXIF  out  one-cycle pulse per received byte
//   FERR    out  stop bit was 0 in the last frame (updated with UxRXIF)
//   PERR    out  even-parity error of the last frame (UART_RX_PARITY_EN only)
//   busy    out  receiver is not idle
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit (11-bit frame) and the PERR output.
// -----------------------------------------------------------------------------
module uart_rx_controller #(
  parameter int CNT_W     = 16,
  parameter int DATA_BITS = uart_rx_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 UxRX,
  input  logic [CNT_W-1:0]     brg,
  input  logic                 rxEn,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 UxRXIF,
  output logic                 FERR,
`ifdef UART_RX_PARITY_EN
  output logic                 PERR,
`endif
  output logic                 busy
);

  import uart_rx_pkg::*;

  localparam int IDX_W = $clog2(DATA_BITS);

  logic                 sync1;
  logic                 rx_s;
  rx_state_t            state;
  rx_state_t            state_next;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic                 tc;
  logic                 timer_load;
  logic [CNT_W-1:0]     timer_val;
  logic                 shift_en;
  logic                 idx_clr;
  logic                 frame_done;
  logic                 last_bit;
`ifdef UART_RX_PARITY_EN
  logic                 par_capture;
  logic                 perr_pend;
`endif

  // Two-flop synchroniser; both flops reset to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= UxRX;
      rx_s  <= sync1;
    end
  end

  uart_bit_timer #(.CNT_W(CNT_W)) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .loadVal (timer_val),
    .tc      (tc)
  );

  assign last_bit = (bit_idx == IDX_W'(DATA_BITS - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control strobes. The timer reloads brg on every tc, which
  // picks up a changed brg at the next reload; only the start detection loads
  // half a bit so that later samples land mid-bit.
  always_comb begin
    state_next  = state;
    shift_en    = 1'b0;
    idx_clr     = 1'b0;
    frame_done  = 1'b0;
    timer_load  = tc;
    timer_val   = brg;
`ifdef UART_RX_PARITY_EN
    par_capture = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (rxEn && (brg >= CNT_W'(2)) && !rx_s) begin
          state_next = ST_START_CHK;
          timer_load = 1'b1;
          timer_val  = brg >> 1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_START_CHK: begin
        if (!rxEn) begin
          state_next = ST_IDLE;
        end else if (tc) begin
          if (rx_s) begin
            state_next = ST_IDLE;  // glitch, not a start bit
          end else begin
            state_next = ST_DATA;
            idx_clr    = 1'b1;
          end
        end else begin
          state_next = ST_START_CHK;
        end
      end
      ST_DATA: begin
        if (!rxEn) begin
          state_next = ST_IDLE;
        end else if (tc) begin
          shift_en = 1'b1;
          if (last_bit) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (!rxEn) begin
          state_next = ST_IDLE;
        end else if (tc) begin
          par_capture = 1'b1;
          state_next  = ST_STOP;
        end else begin
          state_next = ST_PARITY;
        end
`else
        state_next = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (!rxEn) begin
          state_next = ST_IDLE;
        end else if (tc) begin
          frame_done = 1'b1;
          // A low stop bit may be a break; wait for the line to rise first.
          state_next = rx_s ? ST_IDLE : ST_WAIT_HIGH;
        end else begin
          state_next = ST_STOP;
        end
      end
      ST_WAIT_HIGH: begin
        if (!rxEn || rx_s) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. busy follows state_next so it is high
  // in exactly the cycles in which the state register is not Idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift     <= {DATA_BITS{1'b0}};
      bit_idx   <= {IDX_W{1'b0}};
      rxData    <= {DATA_BITS{1'b0}};
      UxRXIF    <= 1'b0;
      FERR      <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PERR      <= 1'b0;
      perr_pend <= 1'b0;
`endif
    end else begin
      UxRXIF <= frame_done;
      busy   <= (state_next != ST_IDLE);
      if (idx_clr) begin
        bit_idx <= {IDX_W{1'b0}};
      end else if (shift_en) begin
        bit_idx <= bit_idx + {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
        bit_idx <= bit_idx;
      end
      if (shift_en) begin
        shift <= {rx_s, shift[DATA_BITS-1:1]};
      end else begin
        shift <= shift;
      end
`ifdef UART_RX_PARITY_EN
      if (par_capture) begin
        perr_pend <= even_parity_err(shift, rx_s);
      end else begin
        perr_pend <= perr_pend;
      end
`endif
      if (frame_done) begin
        rxData <= shift;
        FERR   <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        PERR   <= perr_pend;
`endif
      end else begin
        rxData <= rxData;
        FERR   <= FERR;
`ifdef UART_RX_PARITY_EN
        PERR   <= PERR;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_controller
// Self-checking bench for uart_rx_controller. Frames are built bit by bit from
// the UART frame definition; expected byte, flags and pulse timing come from
// the frame contents and the documented latency formula.
// Honours UART_RX_PARITY_EN (adds the parity bit and PERR checks).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_controller;

  localparam int CNT_W = 16;
`ifdef UART_RX_PARITY_EN
  localparam int BITS_AFTER_START = 10;
`else
  localparam int BITS_AFTER_START = 9;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             UxRX;
  logic [CNT_W-1:0] brg;
  logic             rxEn;
  logic [7:0]       rxData;
  logic             UxRXIF;
  logic             FERR;
  logic             busy;
`ifdef UART_RX_PARITY_EN
  logic             PERR;
`endif

  uart_rx_controller #(.CNT_W(CNT_W), .DATA_BITS(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .UxRX   (UxRX),
    .brg    (brg),
    .rxEn   (rxEn),
    .rxData (rxData),
    .UxRXIF (UxRXIF),
    .FERR   (FERR),
`ifdef UART_RX_PARITY_EN
    .PERR   (PERR),
`endif
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [7:0] last_data;

  logic [7:0] got_data[$];
  logic       got_ferr[$];
  logic       got_perr[$];
  int         got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which the byte-received flag is seen high.
  always @(negedge clk) begin
    if (!rst && UxRXIF) begin
      got_data.push_back(rxData);
      got_ferr.push_back(FERR);
`ifdef UART_RX_PARITY_EN
      got_perr.push_back(PERR);
`else
      got_perr.push_back(1'b0);
`endif
      got_cyc.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    checks++;
    if (got > exp + tol || got < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic clear_q();
    got_data.delete();
    got_ferr.delete();
    got_perr.delete();
    got_cyc.delete();
  endtask

  // Drive one frame starting at a falling clock edge. abort_bit >= 0 drops
  // rxEn halfway through that data bit; rst_in_stop pulses reset in the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stopb,
                            input int b, input int abort_bit, input bit rst_in_stop,
                            output int start_cyc);
    @(negedge clk);
    start_cyc = cyc;
    UxRX = 1'b0;
    repeat (b) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UxRX = d[i];
      if (i == abort_bit) begin
        repeat (b / 2) @(negedge clk);
        rxEn = 1'b0;
        @(negedge clk);
        check_val("abort_busy", int'(busy), 0, 0);
        check_val("abort_flag", int'(UxRXIF), 0, 0);
        repeat (b - b / 2 - 1) @(negedge clk);
      end else begin
        repeat (b) @(negedge clk);
      end
    end
`ifdef UART_RX_PARITY_EN
    UxRX = par;
    repeat (b) @(negedge clk);
`else
    if (par === 1'bx) UxRX = 1'b1;
`endif
    UxRX = stopb;
    if (rst_in_stop) begin
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("rst_rxData", int'(rxData), 0, 0);
      check_val("rst_FERR", int'(FERR), 0, 0);
      check_val("rst_busy", int'(busy), 0, 0);
      check_val("rst_flag", int'(UxRXIF), 0, 0);
`ifdef UART_RX_PARITY_EN
      check_val("rst_PERR", int'(PERR), 0, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      last_data = 8'h00;
      repeat (b - 3) @(negedge clk);
    end else begin
      repeat (b) @(negedge clk);
    end
  endtask

  // Wait (bounded) for the pulse, then compare against the frame model.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic ferr,
                              input logic perr, input int start_cyc, input int b);
    int n;
    int exp_lat;
    exp_lat = 3 + (b >> 1) + BITS_AFTER_START * b;
    n = 0;
    while (got_data.size() == 0 && n < 4 * b + 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_val({tag, "_pulses"}, got_data.size(), 1, 0);
    if (got_data.size() > 0) begin
      check_val({tag, "_data"}, int'(got_data[0]), int'(d), 0);
      check_val({tag, "_ferr"}, int'(got_ferr[0]), int'(ferr), 0);
      check_val({tag, "_latency"}, got_cyc[0] - start_cyc, exp_lat, 1);
`ifdef UART_RX_PARITY_EN
      check_val({tag, "_perr"}, int'(got_perr[0]), int'(perr), 0);
`else
      if (perr === 1'bx) check_val({tag, "_perr"}, int'(got_perr[0]), 0, 0);
`endif
    end
    last_data = d;
    clear_q();
  endtask

  initial begin
    int st;
    int b;
    logic [7:0] d;
    logic stopb;
    logic par;

    rst = 1'b1; UxRX = 1'b1; rxEn = 1'b1; brg = 16'd16;
    last_data = 8'h00;
    #1;
    check_val("reset_rxData", int'(rxData), 0, 0);
    check_val("reset_flag", int'(UxRXIF), 0, 0);
    check_val("reset_FERR", int'(FERR), 0, 0);
    check_val("reset_busy", int'(busy), 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic frame 0xA5, brg 16, latency 155.
    send_frame(8'hA5, 1'b0, 1'b1, 16, -1, 1'b0, st);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0, st, 16);
    check_val("a5_idle", int'(busy), 0, 0);

    // Short glitch: StartChk entered, then rejected.
    @(negedge clk);
    UxRX = 1'b0;
    repeat (4) @(negedge clk);
    UxRX = 1'b1;
    @(negedge clk);
    check_val("glitch_busy_startchk", int'(busy), 1, 0);
    repeat (30) @(negedge clk);
    check_val("glitch_idle", int'(busy), 0, 0);
    check_val("glitch_pulses", got_data.size(), 0, 0);
    check_val("glitch_rxData", int'(rxData), int'(last_data), 0);
    clear_q();

    // Framing error with the line held low afterwards (break).
    brg = 16'd10;
    send_frame(8'h3C, 1'b0, 1'b0, 10, -1, 1'b0, st);
    repeat (50) @(negedge clk);
    expect_frame("ferr", 8'h3C, 1'b1, 1'b0, st, 10);
    check_val("ferr_waithigh_busy", int'(busy), 1, 0);
    UxRX = 1'b1;
    repeat (6) @(negedge clk);
    check_val("ferr_idle", int'(busy), 0, 0);
    check_val("ferr_no_second", got_data.size(), 0, 0);
    clear_q();

    // Receiver disabled during data bit 3.
    brg = 16'd16;
    send_frame(8'hC3, 1'b0, 1'b1, 16, 3, 1'b0, st);
    repeat (5) @(negedge clk);
    check_val("abort_pulses", got_data.size(), 0, 0);
    check_val("abort_rxData", int'(rxData), int'(last_data), 0);
    rxEn = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1, 16, -1, 1'b0, st);
    expect_frame("after_abort", 8'h5A, 1'b0, 1'b0, st, 16);

    // Reset pulse in the stop bit.
    send_frame(8'h81, 1'b0, 1'b1, 16, -1, 1'b1, st);
    repeat (40) @(negedge clk);
    check_val("rst_pulses", got_data.size(), 0, 0);
    check_val("rst_rxData_after", int'(rxData), 0, 0);
    clear_q();

    // brg below 2 blocks the start condition.
    for (int k = 0; k < 2; k++) begin
      brg = CNT_W'(k);
      @(negedge clk);
      UxRX = 1'b0;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        check_val("small_brg_busy", int'(busy), 0, 0);
      end
      UxRX = 1'b1;
      repeat (3) @(negedge clk);
    end
    check_val("small_brg_pulses", got_data.size(), 0, 0);
    clear_q();

`ifdef UART_RX_PARITY_EN
    brg = 16'd8;
    send_frame(8'h07, 1'b1, 1'b1, 8, -1, 1'b0, st);
    expect_frame("par_ok", 8'h07, 1'b0, 1'b0, st, 8);
    send_frame(8'h07, 1'b0, 1'b1, 8, -1, 1'b0, st);
    expect_frame("par_bad", 8'h07, 1'b0, 1'b1, st, 8);
`endif

    // Randomised frames.
    for (int t = 0; t < 24; t++) begin
      b     = int'($urandom_range(4, 24));
      d     = 8'($urandom);
      stopb = ($urandom_range(0, 3) != 0);
      par   = 1'($urandom);
      brg   = CNT_W'(b);
      repeat ($urandom_range(1, 12)) @(negedge clk);
      send_frame(d, par, stopb, b, -1, 1'b0, st);
      expect_frame("rand", d, ~stopb, (^d) ^ par, st, b);
      if (!stopb) begin
        check_val("rand_waithigh", int'(busy), 1, 0);
        UxRX = 1'b1;
        repeat (5) @(negedge clk);
      end
      check_val("rand_idle", int'(busy), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
